// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin arbiter sharing one WIDTH-bit add/subtract unit among NREQ requesters.
// Optional feature macro ADDSUB_RR_ARBITER_CARRY_EN adds a registered res_carry output.

module addsub_rr_arbiter #(
    parameter int WIDTH = 36,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_add,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id
`ifdef ADDSUB_RR_ARBITER_CARRY_EN
    ,
    output logic                  res_carry
`endif
);

    localparam int IW1 = IDW + 1;
    localparam logic [IW1-1:0] NREQ_W  = IW1'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_r;
    logic [IDW-1:0]   rr_r;
    logic [IDW-1:0]   grant_idx_s;
    logic [IDW-1:0]   scan_idx_s;
    logic [IDW-1:0]   rr_next_s;
    logic [IW1-1:0]   scan_sum_s;
    logic [NREQ-1:0]  grant_s;
    logic             found_s;
    logic             hit_s;
    logic             slot_free_s;
    logic             issue_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             op_add_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_data_r;
    logic [IDW-1:0]   res_id_r;

    // Subtraction is a + ~b + 1; bit WIDTH is the carry (1 = no borrow when subtracting).
    function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             add);
        logic [WIDTH-1:0] b_eff;
        b_eff = add ? b : ~b;
        return {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~add};
    endfunction

    assign slot_free_s = (state_r == EMPTY) || res_ready;

    // Round-robin search; scanning downward lets the nearest requester after rr_r win.
    always_comb begin
        grant_idx_s = '0;
        found_s     = 1'b0;
        scan_sum_s  = '0;
        scan_idx_s  = '0;
        hit_s       = 1'b0;
        if (slot_free_s && !reset) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_sum_s  = {1'b0, rr_r} + IW1'(k);
                scan_idx_s  = (scan_sum_s >= NREQ_W) ? IDW'(scan_sum_s - NREQ_W)
                                                     : scan_sum_s[IDW-1:0];
                hit_s       = req_valid[scan_idx_s];
                found_s     = found_s | hit_s;
                grant_idx_s = hit_s ? scan_idx_s : grant_idx_s;
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // One-hot grant and operand selection for the winning requester.
    always_comb begin
        grant_s  = '0;
        op_a_s   = '0;
        op_b_s   = '0;
        op_add_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (found_s && (grant_idx_s == IDW'(i))) begin
                grant_s[i] = 1'b1;
                op_a_s     = req_a[i*WIDTH +: WIDTH];
                op_b_s     = req_b[i*WIDTH +: WIDTH];
                op_add_s   = req_add[i];
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    assign req_ready = grant_s;
    assign issue_s   = |(grant_s & req_valid);
    assign sum_s     = addsub(op_a_s, op_b_s, op_add_s);
    assign rr_next_s = (grant_idx_s == LAST_ID) ? '0 : grant_idx_s + IDW'(1);

    // Result slot FSM, result registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= EMPTY;
            res_data_r <= '0;
            res_id_r   <= '0;
            rr_r       <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (issue_s) state_r <= FULL;
                    else         state_r <= EMPTY;
                end
                FULL: begin
                    if (res_ready && !issue_s) state_r <= EMPTY;
                    else                       state_r <= FULL;
                end
                default: state_r <= EMPTY;
            endcase
            if (issue_s) begin
                res_data_r <= sum_s[WIDTH-1:0];
                res_id_r   <= grant_idx_s;
                rr_r       <= rr_next_s;
            end
        end
    end

`ifdef ADDSUB_RR_ARBITER_CARRY_EN
    logic res_carry_r;

    // Carry/no-borrow flag captured with the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_carry_r <= 1'b0;
        end else if (issue_s) begin
            res_carry_r <= sum_s[WIDTH];
        end
    end

    assign res_carry = res_carry_r;
`else
    logic unused_carry_s;
    assign unused_carry_s = sum_s[WIDTH];
`endif

    assign res_valid = (state_r == FULL);
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed, table-driven bench for addsub_rr_arbiter (NREQ=4, WIDTH=36).
// Also checks res_carry when built with ADDSUB_RR_ARBITER_CARRY_EN.

module tb_addsub_rr_arbiter;

    localparam int WIDTH = 36;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_add;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
`ifdef ADDSUB_RR_ARBITER_CARRY_EN
    logic                  res_carry;
`endif

    int checks;
    int errors;

    addsub_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_add   (req_add),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
`ifdef ADDSUB_RR_ARBITER_CARRY_EN
        ,
        .res_carry (res_carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  rst;
        logic [NREQ-1:0]       valid;
        logic [NREQ*WIDTH-1:0] a;
        logic [NREQ*WIDTH-1:0] b;
        logic [NREQ-1:0]       add;
        logic                  rdy;
        logic [NREQ-1:0]       e_ready;
        logic                  e_rv;
        logic [WIDTH-1:0]      e_data;
        logic [IDW-1:0]        e_id;
        logic                  e_carry;
    } vec_t;

    vec_t tbl[$];

    localparam logic [NREQ*WIDTH-1:0] Z    = '0;
    localparam logic [WIDTH-1:0]      ONES = 36'hF_FFFF_FFFF;

    function automatic logic [NREQ*WIDTH-1:0] ops4(input logic [WIDTH-1:0] x3, input logic [WIDTH-1:0] x2,
                                                   input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] x0);
        return {x3, x2, x1, x0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] valid,
                                input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b,
                                input logic [3:0] add, input logic rdy, input logic [3:0] e_ready,
                                input logic e_rv, input logic [WIDTH-1:0] e_data,
                                input logic [IDW-1:0] e_id, input logic e_carry);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a = a; v.b = b; v.add = add; v.rdy = rdy;
        v.e_ready = e_ready; v.e_rv = e_rv; v.e_data = e_data; v.e_id = e_id; v.e_carry = e_carry;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Drives one cycle of inputs, checks req_ready before the edge and the result after it.
    task automatic apply(input int row, input vec_t v);
        reset     = v.rst;
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        req_add   = v.add;
        res_ready = v.rdy;
        #2;
        chk("req_ready", row, WIDTH'(req_ready), WIDTH'(v.e_ready));
        @(posedge clk);
        #1;
        chk("res_valid", row, WIDTH'(res_valid), WIDTH'(v.e_rv));
        if (v.e_rv || v.rst) begin
            chk("res_data", row, res_data, v.e_data);
            chk("res_id", row, WIDTH'(res_id), WIDTH'(v.e_id));
        end
`ifdef ADDSUB_RR_ARBITER_CARRY_EN
        if (v.e_rv || v.rst) begin
            chk("res_carry", row, WIDTH'(res_carry), WIDTH'(v.e_carry));
        end
`endif
    endtask

    initial begin
        logic [NREQ*WIDTH-1:0] ra;
        logic [NREQ*WIDTH-1:0] rb;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_add   = '0;
        res_ready = 1'b0;
        ra = ops4(36'd3, 36'd2, 36'd1, 36'd0);
        rb = ops4(36'd10, 36'd10, 36'd10, 36'd10);

        // reset then idle; requests during reset must not be granted
        tbl.push_back(mk(1'b1, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        // round-robin fairness, one result per cycle
        tbl.push_back(mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0001, 1'b1, 36'd10, 2'd0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0010, 1'b1, 36'd11, 2'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0100, 1'b1, 36'd12, 2'd2, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b1000, 1'b1, 36'd13, 2'd3, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0001, 1'b1, 36'd10, 2'd0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        // single requester subtract, rr=1
        tbl.push_back(mk(1'b0, 4'b0100, ops4(36'd0, 36'd5, 36'd0, 36'd0), ops4(36'd0, 36'd3, 36'd0, 36'd0),
                         4'b0000, 1'b1, 4'b0100, 1'b1, 36'd2, 2'd2, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        // wrap: 0 - 1 and all-ones + 1
        tbl.push_back(mk(1'b0, 4'b0010, Z, ops4(36'd0, 36'd0, 36'd1, 36'd0),
                         4'b0000, 1'b1, 4'b0010, 1'b1, ONES, 2'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b1000, ops4(ONES, 36'd0, 36'd0, 36'd0), ops4(36'd1, 36'd0, 36'd0, 36'd0),
                         4'b1000, 1'b1, 4'b1000, 1'b1, 36'd0, 2'd3, 1'b1));
        // two contenders alternate, rr starts at 0
        tbl.push_back(mk(1'b0, 4'b0110, ops4(36'd0, 36'd7, 36'd100, 36'd0), ops4(36'd0, 36'd9, 36'd1, 36'd0),
                         4'b0010, 1'b1, 4'b0010, 1'b1, 36'd101, 2'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0110, ops4(36'd0, 36'd7, 36'd100, 36'd0), ops4(36'd0, 36'd9, 36'd1, 36'd0),
                         4'b0010, 1'b1, 4'b0100, 1'b1, 36'hF_FFFF_FFFE, 2'd2, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0110, ops4(36'd0, 36'd7, 36'd100, 36'd0), ops4(36'd0, 36'd9, 36'd1, 36'd0),
                         4'b0010, 1'b1, 4'b0010, 1'b1, 36'd101, 2'd1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            apply(r, tbl[r]);
        end

        // backpressure: result held 3 cycles, then back-to-back grant on release (rr=2 here)
        apply(100, mk(1'b0, 4'b0001, ops4(36'd0, 36'd0, 36'd0, 36'd20), ops4(36'd0, 36'd0, 36'd0, 36'd5),
                      4'b0001, 1'b0, 4'b0001, 1'b1, 36'd25, 2'd0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            apply(101 + c, mk(1'b0, 4'b0001, ops4(36'd0, 36'd0, 36'd0, 36'd40), ops4(36'd0, 36'd0, 36'd0, 36'd8),
                              4'b0000, 1'b0, 4'b0000, 1'b1, 36'd25, 2'd0, 1'b0));
        end
        apply(104, mk(1'b0, 4'b0001, ops4(36'd0, 36'd0, 36'd0, 36'd40), ops4(36'd0, 36'd0, 36'd0, 36'd8),
                      4'b0000, 1'b1, 4'b0001, 1'b1, 36'd32, 2'd0, 1'b1));
        apply(105, mk(1'b0, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));

        // reset mid-operation: held result dropped, rr back to 0 (it was 3)
        apply(200, mk(1'b0, 4'b0100, ops4(36'd0, 36'd1, 36'd0, 36'd0), ops4(36'd0, 36'd2, 36'd0, 36'd0),
                      4'b0100, 1'b0, 4'b0100, 1'b1, 36'd3, 2'd2, 1'b0));
        apply(201, mk(1'b1, 4'b1111, ra, rb, 4'b1111, 1'b0, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));
        apply(202, mk(1'b0, 4'b1111, ra, rb, 4'b1111, 1'b1, 4'b0001, 1'b1, 36'd10, 2'd0, 1'b0));
        apply(203, mk(1'b0, 4'b0000, Z, Z, 4'b0000, 1'b1, 4'b0000, 1'b0, 36'd0, 2'd0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
